// File: rtl/pll_reseq.sv
// rtl/pll_reseq.sv - PLL reconfiguration write sequencer with relock and phase step
// Drives the reconfig management port: row writes, PLL reset, relock wait, optional phase step.
module pll_reseq #(
   parameter int BASE_PHASE   = 29,
   parameter int GAP          = 7,
   parameter int RST_CYCLES   = 8,
   parameter int LOCK_TIMEOUT = 1000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] cfg_m,
   input  logic [31:0] cfg_k,
   input  logic [31:0] cfg_c,
   input  logic [7:0]  cfg_ph,
   input  logic        phase_override,
   input  logic [7:0]  phase_req,
   input  logic        pll_locked,
   output logic        pll_reset,
   output logic [5:0]  mgmt_address,
   output logic [31:0] mgmt_writedata,
   output logic        mgmt_write,
   input  logic        mgmt_waitrequest,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [7:0]  cur_phase
);

   localparam int            CW      = $clog2(LOCK_TIMEOUT + GAP + RST_CYCLES + 1);
   localparam logic [7:0]    BASE8   = 8'(BASE_PHASE);
   localparam logic [CW-1:0] GAP_LD  = CW'(GAP - 1);
   localparam logic [CW-1:0] RST_LD  = CW'(RST_CYCLES - 1);
   localparam logic [CW-1:0] TO_LAST = CW'(LOCK_TIMEOUT - 1);
   localparam logic [3:0]    A_END   = 4'd9;
   localparam logic [3:0]    B_END   = 4'd12;

   typedef enum logic [2:0] {
      S_IDLE, S_WAITLOCK, S_WRITE, S_GAP, S_RST, S_RELOCK, S_FIN
   } state_t;

   state_t        state;
   logic [3:0]    idx;
   logic [CW-1:0] cnt;
   logic [31:0]   lat_m, lat_k, lat_c;
   logic [7:0]    lat_t;
   logic          pend;
   logic          restart_req;
   logic [7:0]    ph_mag;
   logic [31:0]   ph_word;
   logic [5:0]    nxt_addr;
   logic [31:0]   nxt_data;

   assign restart_req = start | pend;
   assign ph_mag  = (lat_t > BASE8) ? (lat_t - BASE8) : (BASE8 - lat_t);
   assign ph_word = {24'd0, ph_mag} | 32'h0001_0000 | ((lat_t < BASE8) ? 32'h0020_0000 : 32'd0);

   // idx 0..8 is the row list, 9..11 the phase-step list; idx always names the next write.
   always_comb begin
      nxt_addr = 6'd0;
      nxt_data = 32'd0;
      case (idx)
         4'd1:    begin nxt_addr = 6'd4; nxt_data = lat_m;                  end
         4'd2:    begin nxt_addr = 6'd7; nxt_data = lat_k;                  end
         4'd3:    begin nxt_addr = 6'd3; nxt_data = 32'h0001_0000;          end
         4'd4:    begin nxt_addr = 6'd5; nxt_data = lat_c;                  end
         4'd5:    begin nxt_addr = 6'd5; nxt_data = lat_c | 32'h0004_0000;  end
         4'd6:    begin nxt_addr = 6'd9; nxt_data = 32'd1;                  end
         4'd7:    begin nxt_addr = 6'd8; nxt_data = 32'd7;                  end
         4'd8:    begin nxt_addr = 6'd2; nxt_data = 32'd0;                  end
         4'd10:   begin nxt_addr = 6'd6; nxt_data = ph_word;                end
         4'd11:   begin nxt_addr = 6'd2; nxt_data = 32'd0;                  end
         default: begin nxt_addr = 6'd0; nxt_data = 32'd0;                  end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         idx            <= 4'd0;
         cnt            <= '0;
         lat_m          <= 32'd0;
         lat_k          <= 32'd0;
         lat_c          <= 32'd0;
         lat_t          <= 8'd0;
         pend           <= 1'b0;
         pll_reset      <= 1'b0;
         mgmt_address   <= 6'd0;
         mgmt_writedata <= 32'd0;
         mgmt_write     <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         err            <= 1'b0;
         cur_phase      <= BASE8;
      end else begin
         done <= 1'b0;
         if (start) begin
            lat_m <= cfg_m;
            lat_k <= cfg_k;
            lat_c <= cfg_c;
            lat_t <= phase_override ? phase_req : cfg_ph;
            err   <= 1'b0;
         end
         // A start during a run abandons it at the next point where no write is in flight.
         if (restart_req && (state == S_WAITLOCK || state == S_GAP ||
                             state == S_RST || state == S_RELOCK)) begin
            pend      <= 1'b0;
            pll_reset <= 1'b0;
            idx       <= 4'd0;
            state     <= S_WAITLOCK;
         end else begin
            case (state)
               S_IDLE, S_FIN: begin
                  if (start) begin
                     busy <= 1'b1;
                     if (pll_locked) begin
                        mgmt_write     <= 1'b1;
                        mgmt_address   <= 6'd0;
                        mgmt_writedata <= 32'd0;
                        idx            <= 4'd1;
                        state          <= S_WRITE;
                     end else begin
                        idx   <= 4'd0;
                        state <= S_WAITLOCK;
                     end
                  end else begin
                     state <= S_IDLE;
                  end
               end
               S_WAITLOCK: begin
                  if (pll_locked) begin
                     mgmt_write     <= 1'b1;
                     mgmt_address   <= nxt_addr;
                     mgmt_writedata <= nxt_data;
                     idx            <= idx + 4'd1;
                     state          <= S_WRITE;
                  end
               end
               S_WRITE: begin
                  if (!mgmt_waitrequest) begin
                     mgmt_write <= 1'b0;
                     if (restart_req) begin
                        pend  <= 1'b0;
                        idx   <= 4'd0;
                        state <= S_WAITLOCK;
                     end else begin
                        cnt   <= GAP_LD;
                        state <= S_GAP;
                     end
                  end else if (start) begin
                     pend <= 1'b1;
                  end
               end
               S_GAP: begin
                  if (cnt != '0) begin
                     cnt <= cnt - CW'(1);
                  end else if (idx == A_END) begin
                     pll_reset <= 1'b1;
                     cnt       <= RST_LD;
                     state     <= S_RST;
                  end else if (idx == B_END) begin
                     done      <= 1'b1;
                     busy      <= 1'b0;
                     cur_phase <= lat_t;
                     state     <= S_FIN;
                  end else if (pll_locked) begin
                     mgmt_write     <= 1'b1;
                     mgmt_address   <= nxt_addr;
                     mgmt_writedata <= nxt_data;
                     idx            <= idx + 4'd1;
                     state          <= S_WRITE;
                  end else begin
                     state <= S_WAITLOCK;
                  end
               end
               S_RST: begin
                  if (cnt != '0) begin
                     cnt <= cnt - CW'(1);
                  end else begin
                     pll_reset <= 1'b0;
                     cnt       <= '0;
                     state     <= S_RELOCK;
                  end
               end
               S_RELOCK: begin
                  if (pll_locked) begin
                     if (lat_t == BASE8) begin
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        cur_phase <= lat_t;
                        state     <= S_FIN;
                     end else begin
                        mgmt_write     <= 1'b1;
                        mgmt_address   <= nxt_addr;
                        mgmt_writedata <= nxt_data;
                        idx            <= idx + 4'd1;
                        state          <= S_WRITE;
                     end
                  end else if (cnt == TO_LAST) begin
                     err   <= 1'b1;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= S_FIN;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pll_reseq.sv
// tb/tb_pll_reseq.sv - scoreboard bench for pll_reseq against a write-list model
`timescale 1ns/1ps
module tb_pll_reseq;

   localparam int BASE   = 29;
   localparam int GAPC   = 7;
   localparam int RSTC   = 8;
   localparam int LT     = 60;
   localparam int K_WR   = 0;
   localparam int K_RST  = 1;
   localparam int K_DONE = 2;

   typedef struct {
      int     kind;
      int     addr;
      longint data;
      int     off;
   } item_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] cfg_m = 32'd0;
   logic [31:0] cfg_k = 32'd0;
   logic [31:0] cfg_c = 32'd0;
   logic [7:0]  cfg_ph = 8'd0;
   logic        phase_override = 1'b0;
   logic [7:0]  phase_req = 8'd0;
   logic        pll_locked = 1'b1;
   logic        pll_reset;
   logic [5:0]  mgmt_address;
   logic [31:0] mgmt_writedata;
   logic        mgmt_write;
   logic        mgmt_waitrequest = 1'b0;
   logic        busy;
   logic        done;
   logic        err;
   logic [7:0]  cur_phase;

   item_t       exp_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          s_cyc = 0;
   int          n_acc = 0;
   int          wr_stamp = 0;
   int          rst_stamp = 0;
   int          cur_ph = BASE;
   int          stall_idx = 0;
   int          stall_left = 0;
   int          lock_mode = 0;
   bit          wr_rand = 1'b0;
   bit          lock_kill = 1'b0;
   bit          prev_wr = 1'b0;
   bit          prev_wait = 1'b0;
   bit          prev_rst = 1'b0;
   logic [5:0]  prev_addr = 6'd0;
   logic [31:0] prev_data = 32'd0;

   pll_reseq #(
      .BASE_PHASE(BASE), .GAP(GAPC), .RST_CYCLES(RSTC), .LOCK_TIMEOUT(LT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .cfg_m(cfg_m), .cfg_k(cfg_k), .cfg_c(cfg_c), .cfg_ph(cfg_ph),
      .phase_override(phase_override), .phase_req(phase_req),
      .pll_locked(pll_locked), .pll_reset(pll_reset),
      .mgmt_address(mgmt_address), .mgmt_writedata(mgmt_writedata),
      .mgmt_write(mgmt_write), .mgmt_waitrequest(mgmt_waitrequest),
      .busy(busy), .done(done), .err(err), .cur_phase(cur_phase)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int kind, input int addr, input longint data, input int off);
      item_t it;
      it.kind = kind; it.addr = addr; it.data = data; it.off = off;
      exp_q.push_back(it);
   endtask

   task automatic take(output item_t it, output bit ok);
      chk("sb_expected_event", longint'(exp_q.size() > 0), 1);
      ok = (exp_q.size() > 0);
      if (ok) it = exp_q.pop_front();
      else it = '{kind: -1, addr: 0, data: 0, off: -1};
   endtask

   // One run as seen on the bus: row list, reset pulse, then phase list or nothing, then done.
   task automatic push_run(input logic [31:0] m, input logic [31:0] k, input logic [31:0] c,
                           input int t, input bit lock_ok, input int sidx, input int st,
                           input bit timed);
      int     a[9];
      longint d[9];
      int     sh, rel;
      longint dd;
      a = '{0, 4, 7, 3, 5, 5, 9, 8, 2};
      d = '{0, longint'(m), longint'(k), 'h10000, longint'(c), longint'(c | 32'h40000), 1, 7, 0};
      for (int i = 0; i < 9; i++) begin
         sh = (sidx != 0 && i + 1 > sidx) ? st : 0;
         push(K_WR, a[i], d[i], timed ? (1 + GAPC) * i + sh : -1);
      end
      rel = (1 + GAPC) * 9 + st;
      push(K_RST, 0, 0, timed ? rel : -1);
      rel = rel + RSTC;
      if (!lock_ok) begin
         push(K_DONE, 0, 'h100 | cur_ph, timed ? rel + LT : -1);
      end else begin
         if (t != BASE) begin
            dd = (t > BASE) ? (longint'(t - BASE) | 'h10000) : (longint'(BASE - t) | 'h210000);
            push(K_WR, 0, 0,  timed ? rel + 1 : -1);
            push(K_WR, 6, dd, timed ? rel + 1 + (1 + GAPC) : -1);
            push(K_WR, 2, 0,  timed ? rel + 1 + 2 * (1 + GAPC) : -1);
            push(K_DONE, 0, t, timed ? rel + 1 + 3 * (1 + GAPC) : -1);
         end else begin
            push(K_DONE, 0, t, timed ? rel + 1 : -1);
         end
         cur_ph = t;
      end
   endtask

   task automatic pulse_start(input logic [31:0] m, input logic [31:0] k, input logic [31:0] c,
                              input int ph, input bit ovr, input int preq);
      @(posedge clk); #1;
      start = 1'b1; cfg_m = m; cfg_k = k; cfg_c = c;
      cfg_ph = 8'(ph); phase_override = ovr; phase_req = 8'(preq);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_empty(input int bound);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < bound) begin
         @(posedge clk);
         n++;
      end
      chk("run_completes_left", longint'(exp_q.size()), 0);
      exp_q.delete();
   endtask

   task automatic run(input logic [31:0] m, input logic [31:0] k, input logic [31:0] c,
                      input int ph, input bit ovr, input int preq, input bit lock_ok,
                      input int sidx, input int st, input bit timed);
      push_run(m, k, c, ovr ? preq : ph, lock_ok, sidx, st, timed);
      stall_idx = sidx; stall_left = st; lock_kill = 1'b0;
      pulse_start(m, k, c, ph, ovr, preq);
      wait_empty(3000);
      repeat (3) @(posedge clk);
   endtask

   // Slave-side drivers: wait states and lock
   initial forever begin
      @(posedge clk); #1;
      if (stall_left > 0 && mgmt_write && n_acc == stall_idx - 1) begin
         mgmt_waitrequest = 1'b1;
         stall_left--;
      end else if (wr_rand) begin
         mgmt_waitrequest = ($urandom_range(0, 9) < 3);
      end else begin
         mgmt_waitrequest = 1'b0;
      end
      if (lock_mode == 2 && pll_reset) lock_kill = 1'b1;
      if (lock_mode == 2 && lock_kill) pll_locked = 1'b0;
      else if (lock_mode == 1)         pll_locked = ($urandom_range(0, 9) < 8);
      else                             pll_locked = 1'b1;
   end

   // Monitor
   initial forever begin
      item_t it;
      bit    ok;
      @(negedge clk);
      if (!rst_n) begin
         prev_wr = 1'b0; prev_wait = 1'b0; prev_rst = 1'b0;
      end else begin
         if (start) begin
            s_cyc = cyc + 1;
            n_acc = 0;
         end
         if (mgmt_write || pll_reset)
            chk("write_reset_exclusive", longint'(mgmt_write & pll_reset), 0);
         if (prev_wr && prev_wait) begin
            chk("hold_write", longint'(mgmt_write), 1);
            chk("hold_addr", longint'(mgmt_address), longint'(prev_addr));
            chk("hold_data", longint'(mgmt_writedata), longint'(prev_data));
         end
         if (mgmt_write && !prev_wr) wr_stamp = cyc;
         if (mgmt_write && !mgmt_waitrequest) begin
            take(it, ok);
            if (ok) begin
               chk("wr_kind", it.kind, K_WR);
               chk("wr_addr", longint'(mgmt_address), it.addr);
               chk("wr_data", longint'(mgmt_writedata), it.data);
               if (it.off >= 0) chk("wr_time", wr_stamp - s_cyc, it.off);
            end
            n_acc++;
         end
         if (pll_reset && !prev_rst) rst_stamp = cyc;
         if (!pll_reset && prev_rst) begin
            take(it, ok);
            if (ok) begin
               chk("rst_kind", it.kind, K_RST);
               chk("rst_width", cyc - rst_stamp, RSTC);
               if (it.off >= 0) chk("rst_time", rst_stamp - s_cyc, it.off);
            end
         end
         if (done) begin
            take(it, ok);
            if (ok) begin
               chk("done_kind", it.kind, K_DONE);
               chk("done_err", longint'(err), (it.data >> 8) & 1);
               chk("done_phase", longint'(cur_phase), it.data & 'hFF);
               chk("done_busy", longint'(busy), 0);
               if (it.off >= 0) chk("done_time", cyc - s_cyc, it.off);
            end
         end
         prev_wr = mgmt_write; prev_wait = mgmt_waitrequest; prev_rst = pll_reset;
         prev_addr = mgmt_address; prev_data = mgmt_writedata;
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pll_reset", longint'(pll_reset), 0);
      chk("rst_mgmt_write", longint'(mgmt_write), 0);
      chk("rst_addr", longint'(mgmt_address), 0);
      chk("rst_data", longint'(mgmt_writedata), 0);
      chk("rst_busy", longint'(busy), 0);
      chk("rst_done", longint'(done), 0);
      chk("rst_err", longint'(err), 0);
      chk("rst_cur_phase", longint'(cur_phase), BASE);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      run(32'h808, 32'hB33332DD, 32'h20302, 29, 1'b0, 0, 1'b1, 0, 0, 1'b1);
      run(32'h808, 32'hB33332DD, 32'h20302, 29, 1'b0, 0, 1'b1, 0, 0, 1'b1);
      run(32'h404, 32'h1, 32'h30302, 14, 1'b0, 0, 1'b1, 0, 0, 1'b1);
      run(32'h808, 32'hB33332DD, 32'h20302, 29, 1'b1, 40, 1'b1, 0, 0, 1'b1);
      run(32'h404, 32'h1, 32'h30302, 14, 1'b1, 29, 1'b1, 0, 0, 1'b1);
      run(32'h808, 32'hB33332DD, 32'h20302, 29, 1'b0, 0, 1'b1, 4, 5, 1'b1);

      lock_mode = 2;
      run(32'h404, 32'h1, 32'h30302, 14, 1'b0, 0, 1'b0, 0, 0, 1'b1);
      chk("err_after_timeout", longint'(err), 1);
      chk("busy_after_timeout", longint'(busy), 0);
      lock_mode = 0;
      repeat (2) @(posedge clk);

      wr_rand = 1'b1; lock_mode = 1;
      for (int r = 0; r < 10; r++) begin
         run($urandom, $urandom, $urandom, int'($urandom_range(0, 100)),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 100)), 1'b1, 0, 0, 1'b0);
      end
      wr_rand = 1'b0; lock_mode = 0;
      repeat (3) @(posedge clk);

      // Restart request landing on the accept edge of write 6
      push_run(32'h808, 32'hB33332DD, 32'h20302, 29, 1'b1, 0, 0, 1'b0);
      pulse_start(32'h808, 32'hB33332DD, 32'h20302, 29, 1'b0, 0);
      n = 0;
      while (!(mgmt_write && n_acc == 5) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("reach_write6", longint'(n < 200), 1);
      while (exp_q.size() > 1) void'(exp_q.pop_back());
      push_run(32'h404, 32'h1, 32'h30302, 14, 1'b1, 0, 0, 1'b0);
      start = 1'b1; cfg_m = 32'h404; cfg_k = 32'h1; cfg_c = 32'h30302;
      cfg_ph = 8'd14; phase_override = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      wait_empty(3000);
      repeat (3) @(posedge clk);

      // Asynchronous reset in the middle of a run
      push_run(32'h808, 32'hB33332DD, 32'h20302, 29, 1'b1, 0, 0, 1'b0);
      pulse_start(32'h808, 32'hB33332DD, 32'h20302, 29, 1'b0, 0);
      n = 0;
      while (n_acc != 3 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_pll_reset", longint'(pll_reset), 0);
      chk("mid_rst_mgmt_write", longint'(mgmt_write), 0);
      chk("mid_rst_addr", longint'(mgmt_address), 0);
      chk("mid_rst_data", longint'(mgmt_writedata), 0);
      chk("mid_rst_busy", longint'(busy), 0);
      chk("mid_rst_done", longint'(done), 0);
      chk("mid_rst_err", longint'(err), 0);
      chk("mid_rst_cur_phase", longint'(cur_phase), BASE);
      exp_q.delete();
      cur_ph = BASE;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      chk("post_rst_busy", longint'(busy), 0);
      chk("post_rst_mgmt_write", longint'(mgmt_write), 0);
      chk("post_rst_cur_phase", longint'(cur_phase), BASE);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
